accum_engine_param: RTL and testbench
=====================================

Name: accum_engine_param

Overview:
- Parameterised accumulator datapath: the next generation of the board-level adder/accumulator.
- Captures an operand from switches and accumulates it on button presses, in add or subtract mode, with configurable width, wrap/saturate arithmetic, sticky overflow and an operation counter.
- A registered byte-wide display mux feeds the seven-segment driver, which sits outside this block.
- Buttons arrive already synchronised; this block does edge detection only.

Parameters:
- DATA_W, 8: operand width (switch bank width).
- ACC_W, 16: accumulator width. Must be >= DATA_W and <= 32.
- CNT_W, 8: operation counter width.
- SATURATE, 0: 0 = wrap on overflow/underflow; 1 = clamp to all-ones/zero.

Ports:
- MCLK  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- din  in  DATA_W  operand from switches.
- load_btn  in  1  level; rising edge loads operand.
- add_btn  in  1  level; rising edge starts one accumulate.
- clear_btn  in  1  level; rising edge clears acc, count, ovf.
- mode  in  1  0 = add, 1 = subtract; sampled when the add pulse is accepted.
- sel  in  3  display select.
- acc_out  out  ACC_W  accumulator value.
- count_out  out  CNT_W  completed-operation count.
- ovf  out  1  sticky overflow/underflow flag.
- busy  out  1  high while in EXEC.
- disp_out  out  8  registered display byte.

Behaviour:
- Reset: when rst_n is low at a rising edge:
  - acc_out, count_out, operand register, ovf, busy and disp_out go to 0.
  - Button history registers go to 0; state goes to IDLE.
  - Reset dominates every other input, including mid-EXEC (no acc update occurs that edge).
- Edge detect: each button is registered (btn_q). pulse = btn & ~btn_q. A held button yields exactly one pulse. After reset, a button already high pulses once on the first edge with rst_n high.
- Priority within one cycle: clear > load > add. A lower-priority pulse coinciding with a higher one is dropped, not queued.
- clear pulse: next edge sets acc = 0, count = 0, ovf = 0 and state = IDLE. This aborts EXEC with no update. The operand register is kept.
- load pulse: next edge sets operand = din. Allowed in any state. If in EXEC, the accumulate in flight uses the previously captured op_q.
- FSM has two states:
  - IDLE: add pulse → EXEC, with op_q = zero-extended operand and mode_q = mode.
  - EXEC: acc = acc ± op_q, count = count + 1 (wraps mod 2^CNT_W), then → IDLE.
- busy = (state == EXEC). Add pulses while in EXEC are ignored.
- Latency: a pulse present before edge k gives a new acc_out after edge k+1. Back-to-back operations are spaced at least 2 cycles apart.
- Arithmetic is unsigned, computed in ACC_W+1 bits.
  - Add: carry out sets ovf. SATURATE=1 → acc = 2^ACC_W−1.
  - Subtract: borrow sets ovf. SATURATE=1 → acc = 0.
  - SATURATE=0 → result truncated to ACC_W bits.
  - ovf stays set until clear or reset.
- Display mux, one-cycle registered latency: disp_out after edge k reflects sel and state before edge k.
  - sel 0..3: acc byte 0..3. Bytes lying entirely above ACC_W read 0; a partial byte is zero-padded.
  - sel 4: operand[7:0], zero-padded if DATA_W < 8.
  - sel 5: count[7:0].
  - sel 6: {5'b0, ovf, busy, mode_q}.
  - sel 7: 0.

Test Plan:
- Reset with all buttons low, then rst_n = 1 → acc_out = 0, count_out = 0, ovf = 0, busy = 0, disp_out = 0. Assert rst_n low during EXEC → acc_out unchanged from before the op, busy = 0 next cycle.
- din = 2, load pulse, then 300 add pulses (mode = 0) each followed by 8 idle cycles → acc_out = 0x0258; sel = 0 gives disp_out = 0x58, sel = 1 gives 0x02; count_out = 0x2C; ovf = 0.
- Hold add_btn high for 10 cycles with operand 5 → exactly one accumulate: acc_out = 5, count_out = 1. busy is high for exactly 1 cycle, and acc is updated 2 edges after the press is first sampled.
- acc = 0, operand 1, mode = 1, add pulse:
  - SATURATE = 0 → acc_out = 0xFFFF, ovf = 1.
  - SATURATE = 1 → acc_out = 0x0000, ovf = 1.
  - Then add 1 (mode = 0) → ovf stays 1 (sticky).
- clear_btn and add_btn rise on the same cycle with acc = 0x0010 → acc_out = 0, count_out = 0, ovf = 0, no EXEC entered. Load and add rising together → operand updated, add dropped.
- ACC_W = 12 instance, acc = 0xFFF, add 1 → acc_out = 0x000, ovf = 1; sel = 1 → disp_out = 0x00 (partial byte zero-padded); sel = 2 → 0x00.

Source files
------------

// File: rtl/accum_engine_param_if.sv
// Switch/button inputs, display select and accumulator status outputs of the accumulator engine.
// The master side drives the inputs and the slave side drives the results.
interface accum_engine_param_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] din;
    logic              load_btn;
    logic              add_btn;
    logic              clear_btn;
    logic              mode;
    logic [2:0]        sel;
    logic [ACC_W-1:0]  acc_out;
    logic [CNT_W-1:0]  count_out;
    logic              ovf;
    logic              busy;
    logic [7:0]        disp_out;

    modport master (
        output din, load_btn, add_btn, clear_btn, mode, sel,
        input  acc_out, count_out, ovf, busy, disp_out
    );

    modport slave (
        input  din, load_btn, add_btn, clear_btn, mode, sel,
        output acc_out, count_out, ovf, busy, disp_out
    );
endinterface

// File: rtl/accum_engine_param.sv
// Button-driven wrap/saturate accumulator with operation counter and registered display mux.
// Accumulate lands two edges after the press is sampled; presses during EXEC are dropped, nothing queues.
module accum_engine_param #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic                 MCLK,
    input  logic                 rst_n,
    accum_engine_param_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              load_q, add_q, clear_q;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [ACC_W-1:0]  op_q, op_d;
    logic              mode_q, mode_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        disp_q, disp_d;

    logic              clear_p, load_p, add_p;
    logic [ACC_W:0]    sum_w, diff_w;
    logic [ACC_W-1:0]  exec_res;
    logic              exec_ovf;
    logic [31:0]       acc_pad;
    logic [7:0]        op_byte, cnt_byte;

    // Priority clear > load > add: a lower pulse in the same cycle is discarded.
    assign clear_p = bus.clear_btn & ~clear_q;
    assign load_p  = bus.load_btn  & ~load_q  & ~clear_p;
    assign add_p   = bus.add_btn   & ~add_q   & ~clear_p & ~load_p;

    assign sum_w  = {1'b0, acc_q} + {1'b0, op_q};
    assign diff_w = {1'b0, acc_q} - {1'b0, op_q};

    always_comb begin
        exec_ovf = 1'b0;
        exec_res = acc_q;
        if (mode_q) begin
            exec_ovf = diff_w[ACC_W];
            exec_res = (exec_ovf && SATURATE != 0) ? '0 : diff_w[ACC_W-1:0];
        end else begin
            exec_ovf = sum_w[ACC_W];
            exec_res = (exec_ovf && SATURATE != 0) ? '1 : sum_w[ACC_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        op_d      = op_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        if (clear_p) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
        end else begin
            if (load_p) begin
                operand_d = bus.din;
            end
            case (state_q)
                IDLE: begin
                    if (add_p) begin
                        state_d = EXEC;
                        op_d    = ACC_W'(operand_q);
                        mode_d  = bus.mode;
                    end
                end
                EXEC: begin
                    acc_d   = exec_res;
                    cnt_d   = cnt_q + CNT_W'(1);
                    ovf_d   = ovf_q | exec_ovf;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Narrow fields are zero-padded up to a full display byte.
    assign acc_pad = 32'(acc_q);

    generate
        if (DATA_W >= 8) begin : g_op_wide
            assign op_byte = operand_q[7:0];
        end else begin : g_op_narrow
            assign op_byte = 8'(operand_q);
        end
        if (CNT_W >= 8) begin : g_cnt_wide
            assign cnt_byte = cnt_q[7:0];
        end else begin : g_cnt_narrow
            assign cnt_byte = 8'(cnt_q);
        end
    endgenerate

    always_comb begin
        disp_d = 8'h00;
        case (bus.sel)
            3'd0:    disp_d = acc_pad[7:0];
            3'd1:    disp_d = acc_pad[15:8];
            3'd2:    disp_d = acc_pad[23:16];
            3'd3:    disp_d = acc_pad[31:24];
            3'd4:    disp_d = op_byte;
            3'd5:    disp_d = cnt_byte;
            3'd6:    disp_d = {5'b00000, ovf_q, state_q == EXEC, mode_q};
            default: disp_d = 8'h00;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            load_q    <= 1'b0;
            add_q     <= 1'b0;
            clear_q   <= 1'b0;
            operand_q <= '0;
            op_q      <= '0;
            mode_q    <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            disp_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            load_q    <= bus.load_btn;
            add_q     <= bus.add_btn;
            clear_q   <= bus.clear_btn;
            operand_q <= operand_d;
            op_q      <= op_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            disp_q    <= disp_d;
        end
    end

    assign bus.acc_out   = acc_q;
    assign bus.count_out = cnt_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = (state_q == EXEC);
    assign bus.disp_out  = disp_q;
endmodule

// File: tb/tb_accum_engine_param.sv
// Drives three accumulator builds (16-bit wrap, 16-bit saturate, 12-bit wrap) with shared stimulus
// and compares each against an arithmetic reference model.
module tb_accum_engine_param;
    logic       MCLK = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       load_btn, add_btn, clear_btn, mode;
    logic [2:0] sel;

    always #5 MCLK = ~MCLK;

    accum_engine_param_if #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) if_w ();
    accum_engine_param_if #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) if_s ();
    accum_engine_param_if #(.DATA_W(8), .ACC_W(12), .CNT_W(8)) if_n ();

    assign if_w.din = din;  assign if_w.load_btn = load_btn;  assign if_w.add_btn = add_btn;
    assign if_w.clear_btn = clear_btn;  assign if_w.mode = mode;  assign if_w.sel = sel;
    assign if_s.din = din;  assign if_s.load_btn = load_btn;  assign if_s.add_btn = add_btn;
    assign if_s.clear_btn = clear_btn;  assign if_s.mode = mode;  assign if_s.sel = sel;
    assign if_n.din = din;  assign if_n.load_btn = load_btn;  assign if_n.add_btn = add_btn;
    assign if_n.clear_btn = clear_btn;  assign if_n.mode = mode;  assign if_n.sel = sel;

    accum_engine_param #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .SATURATE(0))
        u_wrap (.MCLK(MCLK), .rst_n(rst_n), .bus(if_w));
    accum_engine_param #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .SATURATE(1))
        u_sat  (.MCLK(MCLK), .rst_n(rst_n), .bus(if_s));
    accum_engine_param #(.DATA_W(8), .ACC_W(12), .CNT_W(8), .SATURATE(0))
        u_w12  (.MCLK(MCLK), .rst_n(rst_n), .bus(if_n));

    int errors = 0;
    int checks = 0;

    longint unsigned acc_m [3];
    bit              ovf_m [3];
    int              accw  [3] = '{16, 16, 12};
    bit              sat_m [3] = '{1'b0, 1'b1, 1'b0};
    longint unsigned cnt_m, opnd_m;
    bit              mode_m;

    function automatic logic [63:0] get_acc(int i);
        case (i)
            0:       get_acc = 64'(if_w.acc_out);
            1:       get_acc = 64'(if_s.acc_out);
            default: get_acc = 64'(if_n.acc_out);
        endcase
    endfunction

    function automatic logic [63:0] get_cnt(int i);
        case (i)
            0:       get_cnt = 64'(if_w.count_out);
            1:       get_cnt = 64'(if_s.count_out);
            default: get_cnt = 64'(if_n.count_out);
        endcase
    endfunction

    function automatic logic [63:0] get_ovf(int i);
        case (i)
            0:       get_ovf = 64'(if_w.ovf);
            1:       get_ovf = 64'(if_s.ovf);
            default: get_ovf = 64'(if_n.ovf);
        endcase
    endfunction

    function automatic logic [63:0] get_busy(int i);
        case (i)
            0:       get_busy = 64'(if_w.busy);
            1:       get_busy = 64'(if_s.busy);
            default: get_busy = 64'(if_n.busy);
        endcase
    endfunction

    function automatic logic [63:0] get_disp(int i);
        case (i)
            0:       get_disp = 64'(if_w.disp_out);
            1:       get_disp = 64'(if_s.disp_out);
            default: get_disp = 64'(if_n.disp_out);
        endcase
    endfunction

    // Expected display byte while idle, straight from the field definitions.
    function automatic longint unsigned model_disp(int i, int s);
        case (s)
            0, 1, 2, 3: model_disp = (acc_m[i] >> (8 * s)) & 64'hFF;
            4:          model_disp = opnd_m & 64'hFF;
            5:          model_disp = cnt_m & 64'hFF;
            6:          model_disp = (ovf_m[i] ? 4 : 0) + (mode_m ? 1 : 0);
            default:    model_disp = 0;
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic model_add(bit m);
        longint unsigned mx;
        for (int i = 0; i < 3; i++) begin
            mx = (64'd1 << accw[i]) - 1;
            if (!m) begin
                if (acc_m[i] + opnd_m > mx) begin
                    ovf_m[i] = 1'b1;
                    acc_m[i] = sat_m[i] ? mx : ((acc_m[i] + opnd_m) & mx);
                end else begin
                    acc_m[i] = acc_m[i] + opnd_m;
                end
            end else begin
                if (opnd_m > acc_m[i]) begin
                    ovf_m[i] = 1'b1;
                    acc_m[i] = sat_m[i] ? 0 : ((acc_m[i] - opnd_m) & mx);
                end else begin
                    acc_m[i] = acc_m[i] - opnd_m;
                end
            end
        end
        cnt_m  = (cnt_m + 1) % 256;
        mode_m = m;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            acc_m[i] = 0;
            ovf_m[i] = 1'b0;
        end
        cnt_m = 0;
    endtask

    task automatic check_state(string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s acc[%0d]", tag, i),  get_acc(i),  acc_m[i]);
            chk($sformatf("%s cnt[%0d]", tag, i),  get_cnt(i),  cnt_m);
            chk($sformatf("%s ovf[%0d]", tag, i),  get_ovf(i),  64'(ovf_m[i]));
            chk($sformatf("%s busy[%0d]", tag, i), get_busy(i), 64'd0);
        end
    endtask

    task automatic check_disp(string tag, int s);
        sel = 3'(s);
        tick();
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s disp sel%0d [%0d]", tag, s, i), get_disp(i), model_disp(i, s));
    endtask

    task automatic do_load(logic [7:0] v);
        din = v;
        load_btn = 1'b1;
        tick();
        load_btn = 1'b0;
        tick();
        opnd_m = 64'(v);
    endtask

    task automatic do_add(bit m, int idle);
        mode = m;
        add_btn = 1'b1;
        tick();
        add_btn = 1'b0;
        tick();
        repeat (idle) tick();
        model_add(m);
    endtask

    task automatic do_clear();
        clear_btn = 1'b1;
        tick();
        clear_btn = 1'b0;
        tick();
        model_clear();
    endtask

    initial begin
        int busy_cnt;
        int r;
        rst_n = 1'b0; din = 8'h00; load_btn = 1'b0; add_btn = 1'b0;
        clear_btn = 1'b0; mode = 1'b0; sel = 3'd0;
        model_clear();
        opnd_m = 0;
        mode_m = 1'b0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_state("reset");
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset disp[%0d]", i), get_disp(i), 64'd0);

        // Reset asserted while an accumulate is in flight.
        do_load(8'h03);
        add_btn = 1'b1;
        tick();
        chk("rst-exec busy before", get_busy(0), 64'd1);
        add_btn = 1'b0;
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst-exec busy[%0d]", i), get_busy(i), 64'd0);
            chk($sformatf("rst-exec acc[%0d]", i), get_acc(i), 64'd0);
        end
        rst_n = 1'b1;
        tick();
        opnd_m = 0;
        check_state("rst-exec after");
        check_disp("rst-exec", 4);

        // Randomized operation mix.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) do_clear();
            else if (r < 4) do_load(8'($urandom_range(0, 255)));
            else do_add(1'($urandom_range(0, 1)), $urandom_range(0, 2));
            check_state($sformatf("rand%0d", n));
            check_disp($sformatf("rand%0d", n), $urandom_range(0, 7));
        end

        // Long run of small adds.
        do_clear();
        do_load(8'h02);
        for (int n = 0; n < 300; n++) do_add(1'b0, 8);
        check_state("add300");
        chk("add300 acc const", get_acc(0), 64'h258);
        chk("add300 cnt const", get_cnt(0), 64'h2C);
        check_disp("add300", 0);
        check_disp("add300", 1);

        // Held add button yields one operation.
        do_clear();
        do_load(8'h05);
        mode = 1'b0;
        add_btn = 1'b1;
        tick();
        chk("hold busy first edge", get_busy(0), 64'd1);
        chk("hold acc first edge", get_acc(0), 64'd0);
        tick();
        chk("hold acc second edge", get_acc(0), 64'd5);
        chk("hold busy second edge", get_busy(0), 64'd0);
        busy_cnt = 0;
        repeat (8) begin
            tick();
            if (get_busy(0) != 0) busy_cnt++;
        end
        chk("hold extra busy cycles", 64'(busy_cnt), 64'd0);
        add_btn = 1'b0;
        tick();
        model_add(1'b0);
        check_state("hold");

        // Underflow, then sticky overflow.
        do_clear();
        do_load(8'h01);
        do_add(1'b1, 1);
        check_state("underflow");
        chk("underflow wrap const", get_acc(0), 64'hFFFF);
        chk("underflow sat const", get_acc(1), 64'h0000);
        check_disp("underflow", 6);
        do_add(1'b0, 1);
        check_state("sticky");

        // Clear and add together, then load and add together.
        do_clear();
        do_load(8'h10);
        do_add(1'b0, 1);
        check_state("pre-clear");
        clear_btn = 1'b1;
        add_btn = 1'b1;
        tick();
        for (int i = 0; i < 3; i++)
            chk($sformatf("clr+add busy[%0d]", i), get_busy(i), 64'd0);
        clear_btn = 1'b0;
        add_btn = 1'b0;
        tick();
        model_clear();
        check_state("clr+add");
        din = 8'h33;
        load_btn = 1'b1;
        add_btn = 1'b1;
        tick();
        for (int i = 0; i < 3; i++)
            chk($sformatf("ld+add busy[%0d]", i), get_busy(i), 64'd0);
        load_btn = 1'b0;
        add_btn = 1'b0;
        tick();
        opnd_m = 64'h33;
        check_state("ld+add");
        check_disp("ld+add", 4);

        // Drive the 12-bit build to full scale and across it.
        do_clear();
        do_load(8'hFF);
        for (int n = 0; n < 16; n++) do_add(1'b0, 0);
        do_load(8'h0F);
        do_add(1'b0, 0);
        check_state("w12 full");
        check_disp("w12 full", 1);
        do_load(8'h01);
        do_add(1'b0, 0);
        check_state("w12 wrap");
        chk("w12 wrap acc const", get_acc(2), 64'h000);
        chk("w12 wrap ovf const", get_ovf(2), 64'd1);
        check_disp("w12 wrap", 1);
        check_disp("w12 wrap", 2);
        check_disp("w12 wrap", 3);
        check_disp("w12 wrap", 5);
        check_disp("w12 wrap", 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
